// File: rtl/uart_rx_ctrl_if.sv
// Consumer-side bundle of the UART receiver: received word, valid/ready handshake, sticky error flags.
// master = receiver (drives data and flags), slave = consumer (drives ready and error clear).
interface uart_rx_ctrl_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] data_o;
    logic                 valid_o;
    logic                 ready_i;
    logic                 err_clr_i;
    logic                 frame_err_o;
    logic                 overrun_o;

    modport master (
        output data_o, valid_o, frame_err_o, overrun_o,
        input  ready_i, err_clr_i
    );

    modport slave (
        input  data_o, valid_o, frame_err_o, overrun_o,
        output ready_i, err_clr_i
    );
endinterface

// File: rtl/uart_rx_ctrl.sv
// Oversampled UART receiver with 3-sample majority vote and a one-word holding register.
// valid_o rises 1 sysclk after the stop-bit deciding tick; a full register without ready drops the new byte and flags overrun.
module uart_rx_ctrl #(
    parameter int DATA_BITS   = 8,
    parameter int OS_RATE     = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic            sysclk,
    input  logic            reset_n,
    input  logic            os_tick_i,
    input  logic            receive_i,
    uart_rx_ctrl_if.master  bus
);
    localparam int TW = $clog2(OS_RATE);
    localparam int BW = $clog2(DATA_BITS) + 1;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] START = 3'd1;
    localparam logic [2:0] DATA  = 3'd2;
    localparam logic [2:0] STOP  = 3'd3;
    localparam logic [2:0] BREAK = 3'd4;

    localparam logic [TW-1:0] T_HALF = TW'(OS_RATE / 2 - 1);
    localparam logic [TW-1:0] T_S0   = TW'(OS_RATE - 2);
    localparam logic [TW-1:0] T_S1   = TW'(OS_RATE - 1);
    localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_s;
    logic                   rx_prev;
    logic [2:0]             state;
    logic [TW-1:0]          tick_cnt;
    logic [BW-1:0]          bit_cnt;
    logic                   s0;
    logic                   s1;
    logic                   pend;
    logic [DATA_BITS-1:0]   shreg;
    logic [DATA_BITS-1:0]   data_q;
    logic                   valid_q;
    logic                   frame_err_q;
    logic                   overrun_q;
    logic                   vote;
    logic                   bit_done;
    logic                   deliver;
    logic                   frame_bad;

    assign rx_s = sync_q[SYNC_STAGES-1];

    // Samples at the two ticks before the window wrap plus the wrap tick straddle the bit centre.
    assign vote      = (s0 & s1) | (s0 & rx_s) | (s1 & rx_s);
    assign bit_done  = os_tick_i && pend && (tick_cnt == '0);
    assign deliver   = (state == STOP) && bit_done && vote;
    assign frame_bad = (state == STOP) && bit_done && !vote;

    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q  <= '1;
            rx_prev <= 1'b1;
        end else begin
            sync_q  <= (sync_q << 1) | SYNC_STAGES'(receive_i);
            rx_prev <= rx_s;
        end
    end

    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            tick_cnt <= '0;
            bit_cnt  <= '0;
            s0       <= 1'b0;
            s1       <= 1'b0;
            pend     <= 1'b0;
            shreg    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (rx_prev && !rx_s) begin
                        state    <= START;
                        tick_cnt <= '0;
                    end
                end
                START: begin
                    if (os_tick_i) begin
                        if (tick_cnt == T_HALF) begin
                            if (rx_s) begin
                                state <= IDLE;
                            end else begin
                                state    <= DATA;
                                tick_cnt <= '0;
                                bit_cnt  <= '0;
                                pend     <= 1'b0;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                end
                DATA, STOP: begin
                    if (os_tick_i) begin
                        tick_cnt <= (tick_cnt == T_S1) ? '0 : tick_cnt + 1'b1;
                        if (tick_cnt == T_S0) s0 <= rx_s;
                        if (tick_cnt == T_S1) begin
                            s1   <= rx_s;
                            pend <= 1'b1;
                        end
                        if (bit_done) begin
                            pend <= 1'b0;
                            if (state == DATA) begin
                                shreg   <= {vote, shreg[DATA_BITS-1:1]};
                                bit_cnt <= bit_cnt + 1'b1;
                                if (bit_cnt == B_LAST) state <= STOP;
                            end else begin
                                state <= vote ? IDLE : BREAK;
                            end
                        end
                    end
                end
                BREAK: begin
                    if (os_tick_i && rx_s) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            if (deliver && (!valid_q || bus.ready_i)) begin
                data_q  <= shreg;
                valid_q <= 1'b1;
            end else if (valid_q && bus.ready_i) begin
                valid_q <= 1'b0;
            end
            // Clear first so a same-cycle set takes priority.
            if (bus.err_clr_i) begin
                frame_err_q <= 1'b0;
                overrun_q   <= 1'b0;
            end
            if (frame_bad) frame_err_q <= 1'b1;
            if (deliver && valid_q && !bus.ready_i) overrun_q <= 1'b1;
        end
    end

    assign bus.data_o      = data_q;
    assign bus.valid_o     = valid_q;
    assign bus.frame_err_o = frame_err_q;
    assign bus.overrun_o   = overrun_q;
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed and randomized frames against a tick-level line model; expected bytes, flags and delivery
// timing come from the frame rules (bit centres every 16 ticks, stop decided one tick after its centre).
module tb_uart_rx_ctrl;
    localparam int DB  = 8;
    localparam int OSR = 16;

    logic       sysclk    = 1'b0;
    logic       reset_n   = 1'b0;
    logic       receive_i = 1'b1;
    logic [1:0] div       = 2'd0;
    logic       os_tick;

    int         vectors     = 0;
    int         miscompares = 0;
    int         valid_cycles = 0;
    logic [7:0] got[$];
    logic       v_before;
    logic       v_after;

    always #5 sysclk = ~sysclk;
    always @(posedge sysclk) div <= div + 2'd1;
    assign os_tick = (div == 2'd3);

    uart_rx_ctrl_if #(.DATA_BITS(DB)) bus ();

    uart_rx_ctrl #(.DATA_BITS(DB), .OS_RATE(OSR), .SYNC_STAGES(2)) dut (
        .sysclk    (sysclk),
        .reset_n   (reset_n),
        .os_tick_i (os_tick),
        .receive_i (receive_i),
        .bus       (bus)
    );

    always @(posedge sysclk) begin
        if (bus.valid_o) valid_cycles <= valid_cycles + 1;
        if (bus.valid_o && bus.ready_i) got.push_back(bus.data_o);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] got_at(input int i);
        if (i < got.size()) return got[i];
        return 8'hxx;
    endfunction

    // Each iteration consumes exactly one oversample tick; returns at the negedge after it was sampled.
    task automatic pass_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            while (!os_tick) @(negedge sysclk);
            @(negedge sysclk);
        end
    endtask

    // act: 0 none, 1 ready on the stop deciding tick, 2 err_clr on that tick.
    task automatic send_frame(input logic [7:0] d, input logic stop_v, input int stop_ticks,
                              input int glitch_bit, input int act);
        logic r_old;
        pass_ticks(1);
        receive_i = 1'b0;
        pass_ticks(OSR);
        for (int b = 0; b < DB; b++) begin
            receive_i = d[b];
            if (b == glitch_bit) begin
                pass_ticks(OSR / 2 - 1);
                receive_i = ~d[b];
                pass_ticks(1);
                receive_i = d[b];
                pass_ticks(OSR / 2);
            end else begin
                pass_ticks(OSR);
            end
        end
        receive_i = stop_v;
        pass_ticks(OSR / 2);
        while (!os_tick) @(negedge sysclk);
        v_before = bus.valid_o;
        r_old    = bus.ready_i;
        if (act == 1) bus.ready_i = 1'b1;
        if (act == 2) bus.err_clr_i = 1'b1;
        @(negedge sysclk);
        v_after = bus.valid_o;
        bus.ready_i   = r_old;
        bus.err_clr_i = 1'b0;
        pass_ticks(stop_ticks - OSR / 2 - 1);
        receive_i = 1'b1;
    endtask

    task automatic pulse_ready();
        bus.ready_i = 1'b1;
        @(negedge sysclk);
        bus.ready_i = 1'b0;
        @(negedge sysclk);
    endtask

    task automatic pulse_clr();
        bus.err_clr_i = 1'b1;
        @(negedge sysclk);
        bus.err_clr_i = 1'b0;
        @(negedge sysclk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int vc0;
        int rd0;
        logic [7:0] d;
        int gb;

        bus.ready_i   = 1'b0;
        bus.err_clr_i = 1'b0;
        repeat (3) @(negedge sysclk);
        chk("rst_valid", 32'(bus.valid_o), 0);
        chk("rst_data",  32'(bus.data_o), 0);
        chk("rst_ferr",  32'(bus.frame_err_o), 0);
        chk("rst_ovr",   32'(bus.overrun_o), 0);
        reset_n = 1'b1;
        pass_ticks(4);

        // Clean frame with consumer always ready: one-cycle valid pulse.
        bus.ready_i = 1'b1;
        vc0 = valid_cycles; rd0 = got.size();
        send_frame(8'hA5, 1'b1, OSR, -1, 0);
        pass_ticks(2);
        chk("a5_lat_before", 32'(v_before), 0);
        chk("a5_lat_after",  32'(v_after), 1);
        chk("a5_valid_cyc",  32'(valid_cycles - vc0), 1);
        chk("a5_data",       32'(got_at(rd0)), 32'hA5);
        chk("a5_ferr",       32'(bus.frame_err_o), 0);
        chk("a5_ovr",        32'(bus.overrun_o), 0);

        // Short low pulse is rejected as a glitch.
        vc0 = valid_cycles;
        pass_ticks(1);
        receive_i = 1'b0;
        pass_ticks(3);
        receive_i = 1'b1;
        pass_ticks(40);
        chk("glitch_valid", 32'(valid_cycles - vc0), 0);
        chk("glitch_ferr",  32'(bus.frame_err_o), 0);
        chk("glitch_ovr",   32'(bus.overrun_o), 0);
        rd0 = got.size();
        send_frame(8'h5A, 1'b1, OSR, -1, 0);
        pass_ticks(2);
        chk("glitch_next", 32'(got_at(rd0)), 32'h5A);

        // Low stop bit with the line held low for two bit times.
        vc0 = valid_cycles;
        send_frame(8'h3C, 1'b0, 2 * OSR, -1, 0);
        pass_ticks(OSR);
        chk("brk_ferr",  32'(bus.frame_err_o), 1);
        chk("brk_valid", 32'(valid_cycles - vc0), 0);
        rd0 = got.size();
        send_frame(8'h55, 1'b1, OSR, -1, 0);
        pass_ticks(2);
        chk("brk_next",   32'(got_at(rd0)), 32'h55);
        chk("brk_sticky", 32'(bus.frame_err_o), 1);
        pulse_clr();
        chk("brk_clr", 32'(bus.frame_err_o), 0);

        // Overrun: second byte dropped; err_clr on the same cycle loses to the set.
        bus.ready_i = 1'b0;
        send_frame(8'h11, 1'b1, OSR, -1, 0);
        send_frame(8'h22, 1'b1, OSR, -1, 2);
        pass_ticks(2);
        chk("ovr_data",  32'(bus.data_o), 32'h11);
        chk("ovr_valid", 32'(bus.valid_o), 1);
        chk("ovr_flag",  32'(bus.overrun_o), 1);
        pulse_ready();
        chk("ovr_drain", 32'(bus.valid_o), 0);
        pulse_clr();
        chk("ovr_clr", 32'(bus.overrun_o), 0);

        // Accept on the exact delivery cycle replaces the pending byte without overrun.
        send_frame(8'h11, 1'b1, OSR, -1, 0);
        chk("swap_first", 32'(bus.data_o), 32'h11);
        send_frame(8'h22, 1'b1, OSR, -1, 1);
        pass_ticks(2);
        chk("swap_data",  32'(bus.data_o), 32'h22);
        chk("swap_valid", 32'(bus.valid_o), 1);
        chk("swap_ovr",   32'(bus.overrun_o), 0);
        pulse_ready();
        chk("swap_drain", 32'(bus.valid_o), 0);

        // Single-tick glitch at the centre of bit 3 is outvoted.
        bus.ready_i = 1'b1;
        rd0 = got.size();
        send_frame(8'hFF, 1'b1, OSR, 3, 0);
        pass_ticks(2);
        chk("vote_ff", 32'(got_at(rd0)), 32'hFF);

        // Random bytes, random gaps, optional inverted single-tick glitch at a bit centre.
        for (int n = 0; n < 8; n++) begin
            d  = 8'($urandom);
            gb = int'($urandom_range(0, 11));
            if (gb >= DB) gb = -1;
            pass_ticks(int'($urandom_range(1, 20)));
            rd0 = got.size();
            send_frame(d, 1'b1, OSR, gb, 0);
            pass_ticks(2);
            chk("rand_byte", 32'(got_at(rd0)), 32'(d));
        end
        chk("rand_flags", 32'({bus.frame_err_o, bus.overrun_o}), 0);

        // Reset mid-frame abandons it silently.
        pass_ticks(1);
        receive_i = 1'b0;
        pass_ticks(30);
        reset_n = 1'b0;
        @(negedge sysclk);
        chk("mid_rst_valid", 32'(bus.valid_o), 0);
        chk("mid_rst_data",  32'(bus.data_o), 0);
        receive_i = 1'b1;
        @(negedge sysclk);
        reset_n = 1'b1;
        vc0 = valid_cycles;
        pass_ticks(12 * OSR);
        chk("mid_rst_none",  32'(valid_cycles - vc0), 0);
        chk("mid_rst_flags", 32'({bus.frame_err_o, bus.overrun_o}), 0);
        rd0 = got.size();
        send_frame(8'hC3, 1'b1, OSR, -1, 0);
        pass_ticks(2);
        chk("mid_rst_next", 32'(got_at(rd0)), 32'hC3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/uart_rx_ctrl.md
UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8: data bits per frame; supported range 5..8.
REQ-002 SHALL have parameter OS_RATE, default 16: os_tick_i pulses per bit period; must be even and at least 8.
REQ-003 SHALL have parameter SYNC_STAGES, default 2: number of flops in the receive_i synchronizer.
REQ-004 sysclk  input  1  system clock, all logic on the rising edge.
REQ-005 reset_n  input  1  reset; asynchronous assert, active-low.
REQ-006 os_tick_i  input  1  oversample strobe, one sysclk wide, OS_RATE per bit.
REQ-007 receive_i  input  1  asynchronous serial line; idles high.
REQ-008 ready_i  input  1  consumer accepts data_o when ready_i and valid_o are both high.
REQ-009 err_clr_i  input  1  one-cycle pulse that clears overrun_o and frame_err_o.
REQ-010 data_o  output  DATA_BITS  received byte, LSB first on the wire; stable while valid_o is high.
REQ-011 valid_o  output  1  data_o holds an unconsumed byte.
REQ-012 frame_err_o  output  1  sticky flag: the stop bit was sampled low.
REQ-013 overrun_o  output  1  sticky flag: a byte was dropped because the holding register was full.

Function
REQ-014 receive_i SHALL pass through SYNC_STAGES flops, reset value 1; all decisions use the synchronized line (rx_s).
REQ-015 FSM states SHALL be IDLE, START, DATA, STOP, BREAK; the tick counter is log2(OS_RATE) bits wide, and the bit counter is log2(DATA_BITS)+1 bits wide.
REQ-016 IDLE: a 1->0 transition on rx_s SHALL move the FSM to START and clear the tick counter; os_tick_i is not required for this transition.
REQ-017 All counting after IDLE SHALL advance only on os_tick_i; states never change on cycles without a tick, except IDLE->START.
REQ-018 START: at tick OS_RATE/2-1, if rx_s=1 the event is a glitch and the FSM SHALL return to IDLE with no flag set; otherwise it SHALL go to DATA with the tick counter cleared.
REQ-019 DATA: each bit SHALL be the majority of the rx_s samples at ticks OS_RATE-2, OS_RATE-1 and 0 of the bit window (bit-centre relative), then shifted in LSB first.
REQ-020 After DATA_BITS bits the FSM SHALL go to STOP; the stop bit is decided by the same majority rule.
REQ-021 Stop=1: the byte SHALL be offered for delivery on the cycle after the deciding tick; the FSM then returns to IDLE.
REQ-022 Stop=0: the byte SHALL be discarded, frame_err_o SHALL be set, and the FSM SHALL go to BREAK.
REQ-023 BREAK: the FSM SHALL return to IDLE only after rx_s=1 has been seen on one os_tick_i.
REQ-024 Delivery when valid_o=0: load data_o and set valid_o=1.
REQ-025 Delivery when valid_o=1 and ready_i=0: keep the old data_o, drop the new byte, and set overrun_o.
REQ-026 Delivery in the same cycle as an accept (valid_o=1 and ready_i=1): load the new byte, keep valid_o=1, and do not set overrun_o.
REQ-027 An accept with no delivery SHALL clear valid_o on the next edge.
REQ-028 err_clr_i SHALL clear both flags; if a flag is being set in the same cycle, the set wins.
REQ-029 Latency: valid_o SHALL rise 1 sysclk after the stop-bit deciding tick.

Reset
REQ-030 While reset_n=0: FSM=IDLE, all counters=0, synchronizer=1, data_o=0, valid_o=0, frame_err_o=0, overrun_o=0.
REQ-031 Reset asserted mid-frame SHALL abandon the frame without a flag; after release, the first byte is received only on a fresh falling edge.

Verification
REQ-032 Send a frame carrying 0xA5, stop=1, with ready_i=1 -> valid_o is high for 1 cycle with data_o=0xA5 and no flags.
REQ-033 Pulse rx low for 3 ticks -> no valid_o, no flags, and the FSM is back in IDLE.
REQ-034 Send 0x3C with a low stop bit, holding the line low for 2 bit times -> frame_err_o=1, valid_o=0; a following 0x55 is received correctly; err_clr_i clears the flag.
REQ-035 Hold ready_i=0 and send 0x11 then 0x22 -> data_o=0x11, overrun_o=1; after ready_i, valid_o falls.
REQ-036 Assert ready_i on the exact cycle 0x22 is delivered while 0x11 is pending -> data_o=0x22, valid_o=1, overrun_o=0.
REQ-037 Inject a single-tick glitch at the centre of bit 3 of 0xFF -> data_o=0xFF (majority vote rejects the glitch).
